// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared ALU opcode constants and the mul_seq state encoding.
// Imported by the multiply sequencer, its ALU port mux and the ALU bus
// interface.
package mul_seq_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_LUI = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADD  = 3'd1,
      SHL  = 3'd2,
      SHR  = 3'd3,
      DONE = 3'd4
   } mul_state_t;

endpackage

// File: rtl/mul_seq_if.sv
// mul_seq_if: bus between the multiply sequencer and the shared ALU.
//   aluA/aluB  operands to the ALU inputA/inputB
//   aluOp      ALU opcode
//   aluShamt   ALU shift amount
//   aluOut     combinational ALU result
// master = sequencer side (drives operands), slave = ALU side.
interface mul_seq_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] aluA;
   logic [WIDTH-1:0] aluB;
   logic [2:0]       aluOp;
   logic [4:0]       aluShamt;
   logic [WIDTH-1:0] aluOut;

   modport master (
      output aluA, aluB, aluOp, aluShamt,
      input  aluOut
   );

   modport slave (
      input  aluA, aluB, aluOp, aluShamt,
      output aluOut
   );
endinterface

// File: rtl/mul_seq_alu_port_mux.sv
// alu_port_mux: chooses who drives the shared ALU.
//   sel=0 : datapath operands (dpA/dpB/dpOp/dpShamt) pass straight through
//   sel=1 : sequencer operands (seqA/seqB/seqOp/seqShamt)
// Purely combinational.
module alu_port_mux #(
   parameter int WIDTH = 32
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] dpA,
   input  logic [WIDTH-1:0] dpB,
   input  logic [2:0]       dpOp,
   input  logic [4:0]       dpShamt,
   input  logic [WIDTH-1:0] seqA,
   input  logic [WIDTH-1:0] seqB,
   input  logic [2:0]       seqOp,
   input  logic [4:0]       seqShamt,
   output logic [WIDTH-1:0] aluA,
   output logic [WIDTH-1:0] aluB,
   output logic [2:0]       aluOp,
   output logic [4:0]       aluShamt
);
   always_comb begin
      if (sel) begin
         aluA     = seqA;
         aluB     = seqB;
         aluOp    = seqOp;
         aluShamt = seqShamt;
      end else begin
         aluA     = dpA;
         aluB     = dpB;
         aluOp    = dpOp;
         aluShamt = dpShamt;
      end
   end
endmodule

// File: rtl/mul_seq.sv
// mul_seq: multi-cycle unsigned shift-and-add multiplier that borrows the
// CPU's shared ALU. Produces the low WIDTH bits of opA*opB.
//   clk, rst_n        clock, async active-low reset
//   start, opA, opB   request; sampled only when idle
//   busy, stall       high whenever not idle (stall freezes the datapath)
//   done, product     one-cycle completion pulse; product holds until the
//                     next completion
//   dpA/dpB/dpOp/dpShamt  datapath ALU request, passed through when idle
//   alu               ALU bus (master side); sequencer owns it while busy
module mul_seq
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             stall,
   input  logic [WIDTH-1:0] dpA,
   input  logic [WIDTH-1:0] dpB,
   input  logic [2:0]       dpOp,
   input  logic [4:0]       dpShamt,
   mul_seq_if.master        alu
);

   mul_state_t       state, nxt;
   logic [WIDTH-1:0] acc, mc, mp;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] seq_a, seq_b;
   logic [2:0]       seq_op;
   logic [4:0]       seq_sh;
   logic [WIDTH-1:0] mux_a, mux_b;
   logic [2:0]       mux_op;
   logic [4:0]       mux_sh;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // next state and sequencer-side ALU drive; unused fields stay 0
   always_comb begin
      nxt    = state;
      seq_a  = '0;
      seq_b  = '0;
      seq_op = ALU_ADD;
      seq_sh = '0;
      case (state)
         IDLE: begin
            if (start) begin
               if (opB == '0)  nxt = DONE;
               else if (opB[0]) nxt = ADD;
               else             nxt = SHL;
            end
         end
         ADD: begin
            seq_a  = acc;
            seq_b  = mc;
            seq_op = ALU_ADD;
            nxt    = SHL;
         end
         SHL: begin
            seq_b  = mc;
            seq_op = ALU_SLL;
            seq_sh = 5'd1;
            nxt    = SHR;
         end
         SHR: begin
            seq_b  = mp;
            seq_op = ALU_SRL;
            seq_sh = 5'd1;
            // stop early once no multiplier bits remain
            if (alu.aluOut == '0 || cnt == CNT_W'(WIDTH-1)) nxt = DONE;
            else if (alu.aluOut[0])                          nxt = ADD;
            else                                             nxt = SHL;
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // working registers and result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         mc      <= '0;
         mp      <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc <= '0;
                  mc  <= opA;
                  mp  <= opB;
                  cnt <= '0;
                  // zero multiplier skips every step, so load the result now
                  if (opB == '0) product <= '0;
               end
            end
            ADD: acc <= alu.aluOut;
            SHL: mc  <= alu.aluOut;
            SHR: begin
               mp  <= alu.aluOut;
               cnt <= cnt + 1'b1;
               // acc is already final here: ADD never follows the last SHR
               if (nxt == DONE) product <= acc;
            end
            default: ;
         endcase
      end
   end

   assign busy  = (state != IDLE);
   assign stall = busy;
   assign done  = (state == DONE);

   alu_port_mux #(.WIDTH(WIDTH)) u_mux (
      .sel      (busy),
      .dpA      (dpA),
      .dpB      (dpB),
      .dpOp     (dpOp),
      .dpShamt  (dpShamt),
      .seqA     (seq_a),
      .seqB     (seq_b),
      .seqOp    (seq_op),
      .seqShamt (seq_sh),
      .aluA     (mux_a),
      .aluB     (mux_b),
      .aluOp    (mux_op),
      .aluShamt (mux_sh)
   );

   assign alu.aluA     = mux_a;
   assign alu.aluB     = mux_b;
   assign alu.aluOp    = mux_op;
   assign alu.aluShamt = mux_sh;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed bench for mul_seq with a behavioural shared ALU.
// Stimulus pushes expected product and completion cycle into a queue; a
// monitor pops and compares on every done pulse.
module tb_mul_seq;
   import mul_seq_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] opA, opB;
   logic        busy, done, stall;
   logic [31:0] product;
   logic [31:0] dpA, dpB;
   logic [2:0]  dpOp;
   logic [4:0]  dpShamt;

   int unsigned cyc;
   int          n_cmp;
   int          n_fail;

   typedef struct {
      logic [31:0] prod;
      int unsigned at;
   } exp_t;
   exp_t sb[$];

   mul_seq_if #(.WIDTH(32)) alu_bus ();

   mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .opA     (opA),
      .opB     (opB),
      .busy    (busy),
      .done    (done),
      .product (product),
      .stall   (stall),
      .dpA     (dpA),
      .dpB     (dpB),
      .dpOp    (dpOp),
      .dpShamt (dpShamt),
      .alu     (alu_bus)
   );

   // shared ALU model (shifts operate on inputB)
   always_comb begin
      case (alu_bus.aluOp)
         ALU_ADD: alu_bus.aluOut = alu_bus.aluA + alu_bus.aluB;
         ALU_SUB: alu_bus.aluOut = alu_bus.aluA - alu_bus.aluB;
         ALU_AND: alu_bus.aluOut = alu_bus.aluA & alu_bus.aluB;
         ALU_OR:  alu_bus.aluOut = alu_bus.aluA | alu_bus.aluB;
         ALU_XOR: alu_bus.aluOut = alu_bus.aluA ^ alu_bus.aluB;
         ALU_LUI: alu_bus.aluOut = {alu_bus.aluB[15:0], 16'h0000};
         ALU_SLL: alu_bus.aluOut = alu_bus.aluB << alu_bus.aluShamt;
         default: alu_bus.aluOut = alu_bus.aluB >> alu_bus.aluShamt;
      endcase
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check32(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // monitor: every done pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check32("product", product, e.prod);
            check32("done_cycle", cyc, e.at);
         end
      end
   end

   // issue one multiply; lat is the hand-computed step count L
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expp, input int unsigned lat);
      int unsigned bc;
      @(negedge clk);
      opA   = a;
      opB   = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      sb.push_back('{expp, cyc + lat});
      bc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busy) bc++;
         else break;
      end
      check32("busy_len", bc, lat + 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc     = 0;
      n_cmp   = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      opA     = '0;
      opB     = '0;
      dpA     = 32'd7;
      dpB     = 32'd5;
      dpOp    = 3'b000;
      dpShamt = 5'd0;

      // reset and pass-through
      repeat (3) @(negedge clk);
      check32("rst_busy", {31'b0, busy}, 0);
      check32("rst_done", {31'b0, done}, 0);
      check32("rst_stall", {31'b0, stall}, 0);
      check32("rst_product", product, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check32("pt_aluA", alu_bus.aluA, 32'd7);
      check32("pt_aluB", alu_bus.aluB, 32'd5);
      check32("pt_aluOp", {29'b0, alu_bus.aluOp}, 0);
      check32("pt_busy", {31'b0, busy}, 0);

      // multiplies: opB 5 -> L=8, 0 -> 0, 11 -> 11, 16 -> 11, 3 -> 6, all ones -> 96
      do_mul(32'd3, 32'd5, 32'd15, 8);
      do_mul(32'h1234, 32'd0, 32'd0, 0);
      do_mul(32'd6, 32'd11, 32'd66, 11);
      do_mul(32'h12345678, 32'h10, 32'h23456780, 11);
      do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 96);

      // ownership and ignored start: 7 x 9, opB=1001 -> L=10
      @(negedge clk);
      opA     = 32'd7;
      opB     = 32'd9;
      start   = 1'b1;
      dpA     = 32'hDEADBEEF;
      dpB     = 32'hCAFEF00D;
      dpOp    = 3'b100;
      dpShamt = 5'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      sb.push_back('{32'd63, cyc + 10});
      @(negedge clk);
      check32("own_stall", {31'b0, stall}, 1);
      check32("own_add_A", alu_bus.aluA, 32'd0);
      check32("own_add_B", alu_bus.aluB, 32'd7);
      check32("own_add_op", {29'b0, alu_bus.aluOp}, {29'b0, ALU_ADD});
      check32("own_add_sh", {27'b0, alu_bus.aluShamt}, 0);
      opA   = 32'd100;
      opB   = 32'd100;
      start = 1'b1;
      @(negedge clk);
      check32("own_shl_A", alu_bus.aluA, 32'd0);
      check32("own_shl_B", alu_bus.aluB, 32'd7);
      check32("own_shl_op", {29'b0, alu_bus.aluOp}, {29'b0, ALU_SLL});
      check32("own_shl_sh", {27'b0, alu_bus.aluShamt}, 1);
      start = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      check32("own_idle", {31'b0, busy}, 0);
      repeat (20) @(negedge clk);
      check32("own_pt_aluA", alu_bus.aluA, 32'hDEADBEEF);
      check32("own_pt_aluOp", {29'b0, alu_bus.aluOp}, 32'd4);

      // signed operands: -2 x 3 = -6, opB=11 -> L=6
      do_mul(32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 6);

      // abort at edge 4 of 3 x 5
      @(negedge clk);
      opA   = 32'd3;
      opB   = 32'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      rst_n = 1'b0;
      #1;
      check32("abort_busy", {31'b0, busy}, 0);
      check32("abort_product", product, 0);
      check32("abort_done", {31'b0, done}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check32("abort_idle", {31'b0, busy}, 0);

      check32("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
